// File: rtl/sudoku_pkg.sv
// Shared grid geometry, cursor state encoding and divider-free box helpers for the
// Sudoku cell cursor.
package sudoku_pkg;

  localparam int unsigned GRID_DIM  = 9;
  localparam int unsigned BOX_DIM   = 3;
  localparam int unsigned CELLS     = GRID_DIM * GRID_DIM;
  localparam int unsigned IDX_WIDTH = 7;
  localparam int unsigned RC_WIDTH  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StSolved,
    StExhausted
  } cursor_state_e;

  // Box coordinate of a row or column, found by comparing against multiples of BOX_DIM.
  function automatic logic [RC_WIDTH-1:0] box_of(input logic [RC_WIDTH-1:0] v);
    logic [RC_WIDTH-1:0] b;
    b = '0;
    for (int unsigned k = 1; k < BOX_DIM; k++) begin
      if (v >= RC_WIDTH'(k * BOX_DIM)) b = b + RC_WIDTH'(1);
    end
    return b;
  endfunction

  function automatic logic at_box_hi(input logic [RC_WIDTH-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < BOX_DIM; k++) begin
      if (v == RC_WIDTH'(k * BOX_DIM + BOX_DIM - 1)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic at_box_lo(input logic [RC_WIDTH-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < BOX_DIM; k++) begin
      if (v == RC_WIDTH'(k * BOX_DIM)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/sudoku_cell_cursor_if.sv
// Command and status bundle between the backtracking solver and the cell cursor.
interface sudoku_cell_cursor_if;

  logic                               start;
  logic                               fwd;
  logic                               back;
  logic                               load;
  logic [sudoku_pkg::RC_WIDTH-1:0]    load_row;
  logic [sudoku_pkg::RC_WIDTH-1:0]    load_col;
  logic                               wrap_mode;
  logic [sudoku_pkg::IDX_WIDTH-1:0]   index;
  logic [sudoku_pkg::RC_WIDTH-1:0]    row;
  logic [sudoku_pkg::RC_WIDTH-1:0]    col;
  logic [sudoku_pkg::RC_WIDTH-1:0]    box;
  logic                               active;
  logic                               first;
  logic                               last;
  logic                               solved_pulse;
  logic                               exhausted_pulse;
  logic                               load_error;

  modport master (
    output start, fwd, back, load, load_row, load_col, wrap_mode,
    input  index, row, col, box, active, first, last, solved_pulse, exhausted_pulse, load_error
  );

  modport slave (
    input  start, fwd, back, load, load_row, load_col, wrap_mode,
    output index, row, col, box, active, first, last, solved_pulse, exhausted_pulse, load_error
  );

endinterface

// File: rtl/bounded_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load; carry/borrow flag the wrapping step.
module bounded_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] value_d, value_q;
  logic             up, down;

  assign up     = inc && !dec && !ld;
  assign down   = dec && !inc && !ld;
  assign carry  = up && (value_q == MaxVal);
  assign borrow = down && (value_q == '0);

  always_comb begin
    value_d = value_q;
    if (ld) begin
      value_d = ld_val;
    end else if (up) begin
      value_d = carry ? '0 : value_q + WIDTH'(1);
    end else if (down) begin
      value_d = borrow ? MaxVal : value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/sudoku_cell_cursor.sv
// Row-major Sudoku cell cursor: cascaded bounded counters keep index/row/col/box in step
// without a divider; supports back-stepping, direct load and wrap/terminate at the ends.
module sudoku_cell_cursor
  import sudoku_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  sudoku_cell_cursor_if.slave bus
);

  cursor_state_e state_q, state_d;

  logic                 move_fwd, move_back, ld_all;
  logic [RC_WIDTH-1:0]  ld_row, ld_col;
  logic [IDX_WIDTH-1:0] ld_idx;
  logic                 solved_d, exhausted_d, load_err_d;
  logic                 solved_q, exhausted_q, load_err_q;
  logic                 coords_ok, is_first, is_last;

  logic [IDX_WIDTH-1:0] idx_val;
  logic [RC_WIDTH-1:0]  col_val, row_val, bcol_val, brow_val;
  logic                 idx_carry, idx_borrow, col_carry, col_borrow, row_carry, row_borrow;
  logic                 bcol_carry, bcol_borrow, brow_carry, brow_borrow;

  assign coords_ok = (bus.load_row < RC_WIDTH'(GRID_DIM)) && (bus.load_col < RC_WIDTH'(GRID_DIM));
  assign is_first  = (idx_val == '0);
  assign is_last   = (idx_val == IDX_WIDTH'(CELLS - 1));
  assign ld_idx    = IDX_WIDTH'(ld_row) * IDX_WIDTH'(GRID_DIM) + IDX_WIDTH'(ld_col);

  always_comb begin
    state_d     = state_q;
    move_fwd    = 1'b0;
    move_back   = 1'b0;
    ld_all      = 1'b0;
    ld_row      = '0;
    ld_col      = '0;
    solved_d    = 1'b0;
    exhausted_d = 1'b0;
    load_err_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.start) begin
          ld_all = 1'b1;
        end else if (bus.load) begin
          if (coords_ok) begin
            ld_all = 1'b1;
            ld_row = bus.load_row;
            ld_col = bus.load_col;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (bus.fwd && bus.back) begin
          // Conflicting step requests cancel out.
        end else if (bus.fwd) begin
          if (is_last) begin
            solved_d = 1'b1;
            if (bus.wrap_mode) move_fwd = 1'b1;
            else               state_d  = StSolved;
          end else begin
            move_fwd = 1'b1;
          end
        end else if (bus.back) begin
          if (is_first) begin
            exhausted_d = 1'b1;
            if (bus.wrap_mode) move_back = 1'b1;
            else               state_d   = StExhausted;
          end else begin
            move_back = 1'b1;
          end
        end
      end
      default: begin
        if (bus.start) begin
          ld_all  = 1'b1;
          state_d = StRun;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      solved_q    <= 1'b0;
      exhausted_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      solved_q    <= solved_d;
      exhausted_q <= exhausted_d;
      load_err_q  <= load_err_d;
    end
  end

  // Every counter wraps at its modulus, so a wrapping step needs no special load.
  bounded_updown_counter #(.WIDTH(IDX_WIDTH), .MODULUS(CELLS)) u_idx (
    .clock (clock), .reset (reset), .inc (move_fwd), .dec (move_back), .ld (ld_all),
    .ld_val (ld_idx), .value (idx_val), .carry (idx_carry), .borrow (idx_borrow)
  );

  bounded_updown_counter #(.WIDTH(RC_WIDTH), .MODULUS(GRID_DIM)) u_col (
    .clock (clock), .reset (reset), .inc (move_fwd), .dec (move_back), .ld (ld_all),
    .ld_val (ld_col), .value (col_val), .carry (col_carry), .borrow (col_borrow)
  );

  bounded_updown_counter #(.WIDTH(RC_WIDTH), .MODULUS(GRID_DIM)) u_row (
    .clock (clock), .reset (reset), .inc (col_carry), .dec (col_borrow), .ld (ld_all),
    .ld_val (ld_row), .value (row_val), .carry (row_carry), .borrow (row_borrow)
  );

  bounded_updown_counter #(.WIDTH(RC_WIDTH), .MODULUS(BOX_DIM)) u_box_col (
    .clock (clock), .reset (reset),
    .inc (move_fwd && at_box_hi(col_val)), .dec (move_back && at_box_lo(col_val)),
    .ld (ld_all), .ld_val (box_of(ld_col)),
    .value (bcol_val), .carry (bcol_carry), .borrow (bcol_borrow)
  );

  bounded_updown_counter #(.WIDTH(RC_WIDTH), .MODULUS(BOX_DIM)) u_box_row (
    .clock (clock), .reset (reset),
    .inc (col_carry && at_box_hi(row_val)), .dec (col_borrow && at_box_lo(row_val)),
    .ld (ld_all), .ld_val (box_of(ld_row)),
    .value (brow_val), .carry (brow_carry), .borrow (brow_borrow)
  );

  assign bus.index           = idx_val;
  assign bus.row             = row_val;
  assign bus.col             = col_val;
  assign bus.box             = RC_WIDTH'(32'(brow_val) * BOX_DIM + 32'(bcol_val));
  assign bus.active          = (state_q == StRun);
  assign bus.first           = is_first;
  assign bus.last            = is_last;
  assign bus.solved_pulse    = solved_q;
  assign bus.exhausted_pulse = exhausted_q;
  assign bus.load_error      = load_err_q;

  a_index_consistent: assert property (@(posedge clock) disable iff (reset)
    32'(idx_val) == 32'(row_val) * GRID_DIM + 32'(col_val));
  a_box_consistent: assert property (@(posedge clock) disable iff (reset)
    (bcol_val == box_of(col_val)) && (brow_val == box_of(row_val)));
  a_in_range: assert property (@(posedge clock) disable iff (reset)
    (row_val < RC_WIDTH'(GRID_DIM)) && (col_val < RC_WIDTH'(GRID_DIM))
    && (bus.box < RC_WIDTH'(GRID_DIM)));
  a_cascade: assert property (@(posedge clock) disable iff (reset)
    (bcol_carry == col_carry) && (brow_carry == row_carry) && (idx_carry == row_carry)
    && (bcol_borrow == col_borrow) && (brow_borrow == row_borrow)
    && (idx_borrow == row_borrow));

endmodule
